imm_encode: RTL and testbench

IMM_ENCODE -- requirements
Module: imm_encode

---
 rtl/imm_pkg.sv | 13 +
 rtl/imm_pack.sv | 29 ++
 rtl/imm_encode.sv | 64 ++++++
 tb/tb_imm_encode.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: shared format codes, widths and pipeline payload for the immediate encoder
package imm_pkg;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam int INSTR_W = 25;
  localparam int IMM_W = 32;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               err;
  } beat_t;
endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational packing of an immediate into instruction bits [31:7] plus range check (check logic present only with IMM_ENCODE_CHECK_EN)
module imm_pack
  import imm_pkg::*;
(
  input  logic [1:0]         immsrc_i,
  input  logic [IMM_W-1:0]   imm_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               err_o
);
  // Field bits are placed even for out-of-range values, so error beats carry the truncated encoding.
  assign instr_o = immsrc_i == IMM_I ? {imm_i[11:0], 13'b0} :
                   immsrc_i == IMM_S ? {imm_i[11:5], 13'b0, imm_i[4:0]} :
                   immsrc_i == IMM_B ? {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11]} :
                                       {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 5'b0};
`ifdef IMM_ENCODE_CHECK_EN
  logic fit_11, fit_12, fit_20;
  // A value fits when every bit above the top encoded bit copies the sign.
  assign fit_11 = &imm_i[31:11] | ~|imm_i[31:11];
  assign fit_12 = &imm_i[31:12] | ~|imm_i[31:12];
  assign fit_20 = &imm_i[31:20] | ~|imm_i[31:20];
  assign err_o = !immsrc_i[1]       ? !fit_11 :
                 immsrc_i == IMM_B  ? !fit_12 | imm_i[0] :
                                      !fit_20 | imm_i[0];
`else
  logic unused_hi;
  assign unused_hi = ^imm_i[31:21];
  assign err_o = 1'b0;
`endif
endmodule

// File: rtl/imm_encode.sv
// imm_encode: 2-stage valid/ready pipeline encoding immediates into instruction fields; IMM_ENCODE_CHECK_EN enables range errors and the error counter
module imm_encode
  import imm_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [1:0]         IMMSRC,
  input  logic [IMM_W-1:0]   IMM,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [INSTR_W-1:0] INSTR,
  output logic               ERR,
  output logic [7:0]         ERR_CNT
);
  logic [INSTR_W-1:0] pack_instr_d;
  logic               pack_err_d;
  beat_t              s1_q, s2_q;
  logic               v1_q, v2_q, adv1, adv2;
  imm_pack u_pack (
    .immsrc_i (IMMSRC),
    .imm_i    (IMM),
    .instr_o  (pack_instr_d),
    .err_o    (pack_err_d)
  );
  assign adv2      = !v2_q || OUT_READY;
  assign adv1      = !v1_q || adv2;
  assign IN_READY  = adv1 && !RST;
  assign OUT_VALID = v2_q;
  assign INSTR     = s2_q.instr;
  assign ERR       = s2_q.err;
  // Stage 1: capture the packed fields and check result of an accepted beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v1_q <= 1'b0;
      s1_q <= '0;
    end else if (adv1) begin
      v1_q <= IN_VALID;
      if (IN_VALID) s1_q <= '{instr: pack_instr_d, err: pack_err_d};
    end
  end
  // Stage 2: output register, frozen while downstream stalls a valid beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v2_q <= 1'b0;
      s2_q <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) s2_q <= s1_q;
    end
  end
`ifdef IMM_ENCODE_CHECK_EN
  logic [7:0] err_cnt_q;
  // Count delivered error beats, sticking at the maximum.
  always_ff @(posedge CLK) begin
    if (RST) err_cnt_q <= '0;
    else if (v2_q && OUT_READY && s2_q.err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end
  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = '0;
`endif
endmodule

// File: tb/tb_imm_encode.sv
// tb_imm_encode: directed table plus randomized scoreboard bench for imm_encode
module tb_imm_encode;
`ifdef IMM_ENCODE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic        CLK = 1'b0, RST = 1'b1, IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic [1:0]  IMMSRC = '0;
  logic [31:0] IMM = '0;
  logic        IN_READY, OUT_VALID, ERR;
  logic [24:0] INSTR;
  logic [7:0]  ERR_CNT;

  imm_encode dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IMMSRC(IMMSRC), .IMM(IMM), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .INSTR(INSTR), .ERR(ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] imm;
    logic [24:0] instr;
    bit          bad;
    bit          err;
  } exp_t;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] imm;
    logic [24:0] instr;
    bit          err_chk;
  } vec_t;

  int   checks = 0, errors = 0;
  exp_t q[$];
  int   exp_cnt = 0;
  bit   mon_on = 1'b0;
  bit   prev_stall = 1'b0;
  logic [24:0] prev_instr;
  logic        prev_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Which immediate bit lands at instruction-field position p (-1: none).
  function automatic int src_bit(input logic [1:0] f, input int p);
    case (f)
      2'd0:    return p >= 13 ? p - 13 : -1;
      2'd1:    return p >= 18 ? p - 13 : (p <= 4 ? p : -1);
      2'd2:    return p == 24 ? 12 : p == 0 ? 11 : p >= 18 ? p - 13 : (p <= 4 ? p : -1);
      default: return p == 24 ? 20 : p >= 14 ? p - 13 : p == 13 ? 11 : (p >= 5 ? p + 7 : -1);
    endcase
  endfunction

  function automatic exp_t model(input logic [1:0] f, input logic [31:0] d);
    exp_t   m;
    longint v = longint'($signed(d));
    int     s;
    case (f)
      2'd0, 2'd1: m.bad = v < -2048 || v > 2047;
      2'd2:       m.bad = v < -4096 || v > 4095 || d[0];
      default:    m.bad = v < -1048576 || v > 1048575 || d[0];
    endcase
    for (int p = 0; p < 25; p++) begin
      s = src_bit(f, p);
      m.instr[p] = s < 0 ? 1'b0 : d[s];
    end
    m.f = f;
    m.imm = d;
    m.err = CHK && m.bad;
    return m;
  endfunction

  // Sign-extending decode of the instruction fields back into an immediate.
  function automatic logic [31:0] decode(input logic [1:0] f, input logic [24:0] i);
    case (f)
      2'd0:    return {{20{i[24]}}, i[24:13]};
      2'd1:    return {{20{i[24]}}, i[24:18], i[4:0]};
      2'd2:    return {{19{i[24]}}, i[24], i[0], i[23:18], i[4:1], 1'b0};
      default: return {{11{i[24]}}, i[24], i[12:5], i[13], i[23:14], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] rnd_imm();
    logic [31:0] r = $urandom;
    int sh = $urandom_range(0, 31);
    return $signed(r) >>> sh;
  endfunction

  // Scoreboard: tracks accepted beats, checks every delivered beat, stall stability and the error counter.
  always @(negedge CLK) begin
    exp_t e;
    if (prev_stall) begin
      chk("stall_valid", {31'b0, OUT_VALID}, 32'd1);
      chk("stall_instr", {7'b0, INSTR}, {7'b0, prev_instr});
      chk("stall_err", {31'b0, ERR}, {31'b0, prev_err});
    end
    if (mon_on) chk("err_cnt", {24'b0, ERR_CNT}, exp_cnt);
    if (RST) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      if (OUT_VALID && OUT_READY) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_beat: got beat %h with none expected at %0t", INSTR, $time);
        end else begin
          e = q.pop_front();
          chk("out_instr", {7'b0, INSTR}, {7'b0, e.instr});
          chk("out_err", {31'b0, ERR}, {31'b0, e.err});
          if (!e.bad) chk("roundtrip", decode(e.f, INSTR), e.imm);
          if (e.err && exp_cnt < 255) exp_cnt++;
        end
      end
      if (IN_VALID && IN_READY) q.push_back(model(IMMSRC, IMM));
    end
    prev_stall = OUT_VALID && !OUT_READY && !RST;
    prev_instr = INSTR;
    prev_err = ERR;
  end

  // One clock: drive inputs, note whether the beat is accepted, advance to 1 unit past the edge.
  task automatic step(input bit v, input logic [1:0] f, input logic [31:0] d, input bit ordy, output bit acc);
    IN_VALID = v;
    IMMSRC = f;
    IMM = d;
    OUT_READY = ordy;
    #1;
    acc = v && IN_READY;
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && (q.size() != 0 || OUT_VALID); i++) step(0, 2'd0, 32'd0, 1'b1, acc);
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", {31'b0, OUT_VALID}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    bit   acc;
    int   tbl_cnt = 0, sent, cyc;
    bit   r;
    logic [1:0]  f;
    logic [31:0] d;
    vt[0] = '{2'd0, 32'hFFFFF800, 25'h1000000, 1'b0};
    vt[1] = '{2'd2, 32'h00000FFE, 25'h0FC001F, 1'b0};
    vt[2] = '{2'd2, 32'h00000003, 25'h0000002, 1'b1};
    vt[3] = '{2'd3, 32'h00100000, 25'h1000000, 1'b1};
    vt[4] = '{2'd3, 32'hFFF00000, 25'h1000000, 1'b0};
    vt[5] = '{2'd1, 32'h00001000, 25'h0000000, 1'b1};
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      step(0, 2'd0, 32'd0, 1'b1, acc);
      chk("rst_in_ready", {31'b0, IN_READY}, 32'd0);
    end
    RST = 1'b0;
    #1;
    chk("rst_in_ready_after", {31'b0, IN_READY}, 32'd1);
    chk("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("rst_instr", {7'b0, INSTR}, 32'd0);
    chk("rst_err", {31'b0, ERR}, 32'd0);
    chk("rst_err_cnt", {24'b0, ERR_CNT}, 32'd0);
    mon_on = 1'b1;

    // Directed vectors with exact two-edge latency.
    for (int i = 0; i < 6; i++) begin
      step(1, vt[i].f, vt[i].imm, 1'b1, acc);
      chk("vec_accept", {31'b0, acc}, 32'd1);
      chk("vec_lat1_valid", {31'b0, OUT_VALID}, 32'd0);
      step(0, 2'd0, 32'd0, 1'b1, acc);
      chk("vec_valid", {31'b0, OUT_VALID}, 32'd1);
      chk("vec_instr", {7'b0, INSTR}, {7'b0, vt[i].instr});
      chk("vec_err", {31'b0, ERR}, {31'b0, CHK && vt[i].err_chk});
      step(0, 2'd0, 32'd0, 1'b1, acc);
      if (CHK && vt[i].err_chk) tbl_cnt++;
      chk("vec_err_cnt", {24'b0, ERR_CNT}, tbl_cnt);
      chk("vec_done", {31'b0, OUT_VALID}, 32'd0);
    end

    // Eight back-to-back random beats with OUT_READY alternating.
    sent = 0;
    cyc = 0;
    r = 1'b1;
    f = 2'($urandom);
    d = rnd_imm();
    while (sent < 8 && cyc < 100) begin
      step(1, f, d, r, acc);
      if (acc) begin
        sent++;
        f = 2'($urandom);
        d = rnd_imm();
      end
      r = !r;
      cyc++;
    end
    chk("b2b_sent", sent, 8);
    drain();

    // Random valid/ready traffic.
    sent = 0;
    cyc = 0;
    while (sent < 200 && cyc < 2000) begin
      step($urandom_range(0, 3) != 0, f, d, $urandom_range(0, 2) != 0, acc);
      if (acc) begin
        sent++;
        f = 2'($urandom);
        d = rnd_imm();
      end
      cyc++;
    end
    chk("rand_sent", sent, 200);
    drain();

    // 300 error beats to saturate the counter.
    sent = 0;
    cyc = 0;
    while (sent < 300 && cyc < 400) begin
      step(1, 2'd2, 32'h00000001, 1'b1, acc);
      if (acc) sent++;
      cyc++;
    end
    chk("sat_sent", sent, 300);
    drain();
    chk("sat_err_cnt", {24'b0, ERR_CNT}, CHK ? 32'd255 : 32'd0);

    // Reset while the pipeline is full and stalled.
    step(1, 2'd0, 32'h00000123, 1'b0, acc);
    step(1, 2'd1, 32'hFFFFFFF0, 1'b0, acc);
    chk("mid_full_valid", {31'b0, OUT_VALID}, 32'd1);
    RST = 1'b1;
    step(0, 2'd0, 32'd0, 1'b0, acc);
    RST = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("mid_rst_err_cnt", {24'b0, ERR_CNT}, 32'd0);
    chk("mid_rst_ready", {31'b0, IN_READY}, 32'd1);
    step(0, 2'd0, 32'd0, 1'b1, acc);
    chk("mid_rst_flushed", {31'b0, OUT_VALID}, 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
